shift_unit_p: RTL and testbench

Parametrised shift register and sequential shifter for the multi-clock CPU datapath. It keeps the 74LS194-style direct modes: hold, shift right, shift left and parallel load, all selected by S1/S0. It adds a command mode that loads an operand and shifts it by a programmed amount, one bit per clock, under a start/busy/done handshake. The ALU shift path uses it for SLL/SRL/SRA/rotate.

---
 rtl/shift_unit_p_if.sv | 35 +++
 rtl/shift_unit_p.sv | 120 ++++++++++++
 tb/tb_shift_unit_p.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_p_if.sv
// Bus bundle for shift_unit_p: direct-mode controls, command handshake and
// register outputs. The master drives controls; the shifter is the slave.
//
// Handshake: start is a one-cycle strobe sampled only while busy=0.
// The command is accepted on that edge. busy stays high for exactly amt
// cycles, and done pulses for one cycle when the result is final in Q.
// A new start may be issued during the done cycle.
interface shift_unit_p_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH)
);
  logic             S1;
  logic             S0;
  logic             SR;
  logic             SL;
  logic [WIDTH-1:0] PData;
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] Q;
  logic             cout;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output S1, S0, SR, SL, PData, start, op, amt,
    input  Q, cout, busy, done, state
  );

  modport slave (
    input  S1, S0, SR, SL, PData, start, op, amt,
    output Q, cout, busy, done, state
  );
endinterface

// File: rtl/shift_unit_p.sv
// 74LS194-style shift register with hold/shift-right/shift-left/load direct
// modes, plus a command mode that loads an operand and shifts it one bit per
// clock by a programmed amount (SLL/SRL/SRA/ROL/ROR/serial-fill).
module shift_unit_p #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           clear_n,
  shift_unit_p_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic [2:0]       op_r;
  logic [AMT_W-1:0] cnt;
  logic             busy;
  logic             done;

  // One-bit shift result and outgoing bit for the latched command.
  logic [WIDTH-1:0] run_q;
  logic             run_cout;

  // State register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: a start in IDLE/DONE wins over the direct modes; RUN ends on
  // the shift that consumes the last count.
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_nx = (bus.amt != '0) ? RUN : DONE;
        else           state_nx = IDLE;
      end
      RUN:     state_nx = (cnt == AMT_W'(1)) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Single-step shift for each command op; reserved op holds Q and cout.
  always_comb begin
    run_q    = q;
    run_cout = cout;
    case (op_r)
      3'b000: begin run_q = {q[WIDTH-2:0], 1'b0};     run_cout = q[WIDTH-1]; end
      3'b001: begin run_q = {1'b0, q[WIDTH-1:1]};     run_cout = q[0];       end
      3'b010: begin run_q = {q[WIDTH-1], q[WIDTH-1:1]}; run_cout = q[0];     end
      3'b011: begin run_q = {q[WIDTH-2:0], q[WIDTH-1]}; run_cout = q[WIDTH-1]; end
      3'b100: begin run_q = {q[0], q[WIDTH-1:1]};     run_cout = q[0];       end
      3'b101: begin run_q = {q[WIDTH-2:0], bus.SL};   run_cout = q[WIDTH-1]; end
      3'b110: begin run_q = {bus.SR, q[WIDTH-1:1]};   run_cout = q[0];       end
      default: begin run_q = q;                       run_cout = cout;       end
    endcase
  end

  // Datapath: command load or direct mode outside RUN, counted shifts in RUN.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q    <= '0;
      cout <= 1'b0;
      op_r <= 3'b000;
      cnt  <= '0;
    end else if (state == RUN) begin
      q    <= run_q;
      cout <= run_cout;
      cnt  <= cnt - AMT_W'(1);
    end else if (bus.start) begin
      q    <= bus.PData;
      op_r <= bus.op;
      cnt  <= bus.amt;
      cout <= 1'b0;
    end else begin
      case ({bus.S1, bus.S0})
        2'b01: begin
          q    <= {bus.SR, q[WIDTH-1:1]};
          cout <= q[0];
        end
        2'b10: begin
          q    <= {q[WIDTH-2:0], bus.SL};
          cout <= q[WIDTH-1];
        end
        2'b11: begin
          q    <= bus.PData;
          cout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.Q     = q;
  assign bus.cout  = cout;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.state = state;

endmodule

// File: tb/tb_shift_unit_p.sv
// Directed self-checking bench for shift_unit_p: a 32-bit unit for direct
// modes and commands, and an 8-bit unit for the narrow-width case.
module tb_shift_unit_p;

  logic clk;
  logic clear_n;

  int n_checks = 0;
  int n_errors = 0;

  shift_unit_p_if #(.WIDTH(32)) bus32 ();
  shift_unit_p_if #(.WIDTH(8))  bus8 ();

  shift_unit_p #(.WIDTH(32)) dut32 (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus32)
  );

  shift_unit_p #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus8)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    bus32.S1 = 0; bus32.S0 = 0; bus32.SR = 0; bus32.SL = 0;
    bus32.PData = '0; bus32.start = 0; bus32.op = 3'b000; bus32.amt = '0;
  endtask

  // Issue a command on the 32-bit unit and wait (bounded) for done.
  // edges counts E0 plus every following edge up to the one that raised done.
  task automatic run32(input logic [31:0] pdata, input logic [2:0] op,
                       input logic [4:0] amt, output int busy_cycles,
                       output int edges);
    bus32.PData = pdata; bus32.op = op; bus32.amt = amt; bus32.start = 1;
    tick();
    bus32.start = 0;
    busy_cycles = 0;
    edges = 1;
    while (!bus32.done && edges < 100) begin
      if (bus32.busy) busy_cycles++;
      tick();
      edges++;
    end
  endtask

  int bc;
  int ed;
  int done_seen;

  initial begin
    idle32();
    bus8.S1 = 0; bus8.S0 = 0; bus8.SR = 0; bus8.SL = 0;
    bus8.PData = '0; bus8.start = 0; bus8.op = 3'b000; bus8.amt = '0;

    // Reset state.
    clear_n = 0;
    tick();
    tick();
    check("reset_q", bus32.Q, 32'h0);
    check("reset_cout", {31'b0, bus32.cout}, 32'h0);
    check("reset_busy", {31'b0, bus32.busy}, 32'h0);
    check("reset_done", {31'b0, bus32.done}, 32'h0);
    check("reset_state", {30'b0, bus32.state}, 32'h0);
    clear_n = 1;
    tick();

    // Direct modes.
    bus32.S1 = 1; bus32.S0 = 1; bus32.PData = 32'h8000_0001;
    tick();
    check("load_q", bus32.Q, 32'h8000_0001);
    bus32.S1 = 0; bus32.S0 = 1; bus32.SR = 1;
    tick();
    check("shr_q", bus32.Q, 32'hC000_0000);
    check("shr_cout", {31'b0, bus32.cout}, 32'h1);
    bus32.S1 = 1; bus32.S0 = 0; bus32.SR = 0; bus32.SL = 1;
    tick();
    check("shl_q", bus32.Q, 32'h8000_0001);
    check("shl_cout", {31'b0, bus32.cout}, 32'h1);
    idle32();
    bus32.PData = 32'hFFFF_FFFF;
    tick();
    tick();
    check("hold_q", bus32.Q, 32'h8000_0001);
    check("hold_cout", {31'b0, bus32.cout}, 32'h1);

    // SRA by 4.
    idle32();
    run32(32'h8000_00F0, 3'b010, 5'd4, bc, ed);
    check("sra_busy_cycles", bc, 4);
    check("sra_edges", ed, 5);
    check("sra_done", {31'b0, bus32.done}, 32'h1);
    check("sra_q", bus32.Q, 32'hF800_000F);
    check("sra_cout", {31'b0, bus32.cout}, 32'h0);
    tick();
    check("done_one_cycle", {31'b0, bus32.done}, 32'h0);

    // ROL by 8, then ROR by 8 issued during DONE.
    run32(32'h1234_5678, 3'b011, 5'd8, bc, ed);
    check("rol_edges", ed, 9);
    check("rol_q", bus32.Q, 32'h3456_7812);
    check("rol_cout", {31'b0, bus32.cout}, 32'h0);
    run32(bus32.Q, 3'b100, 5'd8, bc, ed);
    check("ror_b2b_edges", ed, 9);
    check("ror_q", bus32.Q, 32'h1234_5678);
    tick();

    // amt = 0: done the cycle after acceptance, busy never high.
    run32(32'hDEAD_BEEF, 3'b000, 5'd0, bc, ed);
    check("amt0_edges", ed, 1);
    check("amt0_busy_cycles", bc, 0);
    check("amt0_done", {31'b0, bus32.done}, 32'h1);
    check("amt0_q", bus32.Q, 32'hDEAD_BEEF);
    tick();

    // start beats a simultaneous direct mode.
    bus32.S1 = 0; bus32.S0 = 1; bus32.SR = 1;
    run32(32'h0000_0005, 3'b001, 5'd0, bc, ed);
    check("start_prio_q", bus32.Q, 32'h0000_0005);
    idle32();
    tick();

    // Left shift with live SL fill.
    bus32.SL = 1;
    run32(32'h0000_0000, 3'b101, 5'd4, bc, ed);
    check("sl_fill_q", bus32.Q, 32'h0000_000F);
    check("sl_fill_cout", {31'b0, bus32.cout}, 32'h0);
    idle32();
    tick();

    // Reserved op: Q holds, count still runs.
    run32(32'hA5A5_A5A5, 3'b111, 5'd3, bc, ed);
    check("rsvd_edges", ed, 4);
    check("rsvd_q", bus32.Q, 32'hA5A5_A5A5);
    tick();

    // SLL by 31 with disturbances during RUN, then reset mid-run.
    bus32.PData = 32'h1; bus32.op = 3'b000; bus32.amt = 5'd31; bus32.start = 1;
    tick();
    bus32.start = 0;
    for (int i = 0; i < 10; i++) begin
      bus32.S1 = 1; bus32.S0 = 1; bus32.PData = 32'hFFFF_FFFF;
      bus32.start = (i % 2 == 0);
      bus32.op = 3'b100; bus32.amt = 5'd1;
      tick();
    end
    check("run_ignores_q", bus32.Q, 32'h0000_0400);
    check("run_busy", {31'b0, bus32.busy}, 32'h1);
    idle32();
    #2;
    clear_n = 0;
    #1;
    check("async_clr_q", bus32.Q, 32'h0);
    check("async_clr_busy", {31'b0, bus32.busy}, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus32.done) done_seen = 1;
    end
    clear_n = 1;
    tick();
    if (bus32.done) done_seen = 1;
    check("clr_no_done", done_seen, 0);
    run32(32'h1, 3'b000, 5'd31, bc, ed);
    check("sll31_edges", ed, 32);
    check("sll31_q", bus32.Q, 32'h8000_0000);
    check("sll31_cout", {31'b0, bus32.cout}, 32'h0);
    tick();

    // Narrow unit: SRL by 7 on 0xFF.
    bus8.PData = 8'hFF; bus8.op = 3'b001; bus8.amt = 3'd7; bus8.start = 1;
    tick();
    bus8.start = 0;
    ed = 1;
    while (!bus8.done && ed < 100) begin
      tick();
      ed++;
    end
    check("w8_edges", ed, 8);
    check("w8_q", {24'b0, bus8.Q}, 32'h0000_0001);
    check("w8_cout", {31'b0, bus8.cout}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
